// File: rtl/valid_sweep_pkg.sv
// rtl/valid_sweep_pkg.sv - shared defaults and state type for the valid-bit sweep controller
package valid_sweep_pkg;

  localparam int LINES_DEFAULT   = 1024;
  localparam int INDEX_W_DEFAULT = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_WB    = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DONE  = 3'd4
  } sweep_state_e;

endpackage

// File: rtl/valid_sweep_ctrl.sv
// rtl/valid_sweep_ctrl.sv - walks every cache line, writes back valid lines if asked, then clears their valid bit
module valid_sweep_ctrl
  import valid_sweep_pkg::*;
#(
  parameter int LINES   = LINES_DEFAULT,
  parameter int INDEX_W = INDEX_W_DEFAULT
) (
  input  logic               globalclock,
  input  logic               reset,
  input  logic               flush_req,
  input  logic               flush_mode,
  output logic               flush_busy,
  output logic               flush_done,
  output logic [INDEX_W-1:0] vm_address,
  output logic               vm_wrEn,
  output logic               vm_inValidity,
  input  logic               vm_isValid,
  output logic               wb_req,
  output logic [INDEX_W-1:0] wb_index,
  input  logic               wb_ack,
  output logic [INDEX_W:0]   lines_cleared
);

  sweep_state_e       state_q, state_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic               mode_q, mode_d;
  logic [INDEX_W:0]   cleared_q, cleared_d;
  logic               advance;
  logic               last_line;

  assign last_line = (idx_q == INDEX_W'(LINES - 1));

  always_ff @(posedge globalclock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      mode_q    <= 1'b0;
      cleared_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      cleared_q <= cleared_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    cleared_d = cleared_q;
    advance   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          idx_d     = '0;
          mode_d    = flush_mode;
          cleared_d = '0;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!vm_isValid) begin
          advance = 1'b1;
        end else begin
          state_d = mode_q ? ST_CLEAR : ST_WB;
        end
      end
      ST_WB: begin
        if (wb_ack) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cleared_d = cleared_q + 1'b1;
        advance   = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The last line ends the sweep instead of wrapping the index.
    if (advance) begin
      if (last_line) begin
        state_d = ST_DONE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = ST_CHECK;
      end
    end
  end

  always_comb begin
    flush_busy    = (state_q != ST_IDLE);
    flush_done    = (state_q == ST_DONE);
    vm_address    = (state_q == ST_IDLE) ? '0 : idx_q;
    vm_wrEn       = (state_q == ST_CLEAR);
    vm_inValidity = 1'b0;
    wb_req        = (state_q == ST_WB);
    wb_index      = (state_q == ST_WB) ? idx_q : '0;
    lines_cleared = cleared_q;
  end

endmodule

// File: tb/tb_valid_sweep_ctrl.sv
// tb/tb_valid_sweep_ctrl.sv - scoreboard bench for valid_sweep_ctrl with VMemory and RAM-interface models
module tb_valid_sweep_ctrl;
  import valid_sweep_pkg::*;

  localparam int LINES   = LINES_DEFAULT;
  localparam int INDEX_W = INDEX_W_DEFAULT;
  localparam int BOUND   = 8000;

  typedef struct { int idx; int len; } wb_exp_t;
  typedef struct { int lat; int lines; } done_exp_t;

  logic               globalclock = 1'b0;
  logic               reset;
  logic               flush_req;
  logic               flush_mode;
  logic               flush_busy;
  logic               flush_done;
  logic [INDEX_W-1:0] vm_address;
  logic               vm_wrEn;
  logic               vm_inValidity;
  logic               vm_isValid;
  logic               wb_req;
  logic [INDEX_W-1:0] wb_index;
  logic               wb_ack;
  logic [INDEX_W:0]   lines_cleared;

  int errors = 0;
  int checks = 0;

  wb_exp_t   exp_wb[$];
  int        exp_clr[$];
  done_exp_t exp_done[$];
  int        set_q[$];
  int        sweep_set[$];

  logic [LINES-1:0] vmem;
  int  ack_delay = 0;
  bit  stray_en  = 1'b0;

  int      last_gap = 0, idle_run = 0, busy_cyc = 0, wb_run = 0;
  bit      prev_wb = 1'b0, prev_busy = 1'b0, have_cur = 1'b0;
  wb_exp_t cur_wb;

  always #5 globalclock = ~globalclock;

  valid_sweep_ctrl #(.LINES(LINES), .INDEX_W(INDEX_W)) dut (
    .globalclock   (globalclock),
    .reset         (reset),
    .flush_req     (flush_req),
    .flush_mode    (flush_mode),
    .flush_busy    (flush_busy),
    .flush_done    (flush_done),
    .vm_address    (vm_address),
    .vm_wrEn       (vm_wrEn),
    .vm_inValidity (vm_inValidity),
    .vm_isValid    (vm_isValid),
    .wb_req        (wb_req),
    .wb_index      (wb_index),
    .wb_ack        (wb_ack),
    .lines_cleared (lines_cleared)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // VMemory: combinational read, clocked write, cleared by the shared reset.
  assign vm_isValid = vmem[vm_address];

  always @(posedge globalclock or posedge reset) begin
    if (reset) begin
      vmem <= '0;
    end else begin
      automatic logic [LINES-1:0] nxt = vmem;
      if (vm_wrEn) nxt[vm_address] = vm_inValidity;
      while (set_q.size() > 0) nxt[set_q.pop_front()] = 1'b1;
      vmem <= nxt;
    end
  end

  // RAM interface: acks ack_delay cycles into each request, random noise elsewhere.
  initial begin
    automatic int wcnt = 0;
    wb_ack = 1'b0;
    forever begin
      @(negedge globalclock);
      wb_ack = 1'b0;
      if (wb_req && !reset) begin
        if (wcnt == ack_delay) begin
          wb_ack = 1'b1;
          wcnt   = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
        if (stray_en) wb_ack = 1'($urandom_range(0, 1));
      end
    end
  end

  always @(negedge globalclock) begin
    if (reset) begin
      prev_wb   = 1'b0;
      prev_busy = 1'b0;
      have_cur  = 1'b0;
      wb_run    = 0;
      idle_run  = 0;
    end else begin
      if (flush_busy) busy_cyc = prev_busy ? busy_cyc + 1 : 1;
      if (flush_busy && !prev_busy) begin
        last_gap = idle_run;
        idle_run = 0;
      end
      if (!flush_busy) begin
        idle_run++;
        chk("idle_outputs", longint'({vm_address, vm_wrEn, wb_req}), 0);
      end

      if (wb_req) begin
        if (!prev_wb) begin
          wb_run = 1;
          if (exp_wb.size() == 0) begin
            chk("wb_unexpected", longint'(wb_req), 0);
          end else begin
            cur_wb   = exp_wb.pop_front();
            have_cur = 1'b1;
            chk("wb_index", longint'(wb_index), cur_wb.idx);
          end
        end else begin
          wb_run++;
          if (have_cur) chk("wb_hold", longint'(wb_index), cur_wb.idx);
        end
      end else if (prev_wb && have_cur) begin
        chk("wb_len", wb_run, cur_wb.len);
        have_cur = 1'b0;
      end

      if (vm_wrEn) begin
        if (exp_clr.size() == 0) chk("clr_unexpected", longint'(vm_wrEn), 0);
        else chk("clr_addr", longint'(vm_address), exp_clr.pop_front());
      end

      if (flush_done) begin
        if (exp_done.size() == 0) begin
          chk("done_unexpected", longint'(flush_done), 0);
        end else begin
          automatic done_exp_t d = exp_done.pop_front();
          chk("done_latency", busy_cyc, d.lat);
          chk("done_lines", longint'(lines_cleared), d.lines);
        end
      end

      prev_wb   = wb_req;
      prev_busy = flush_busy;
    end
  end

  // Reference model: every valid line in ascending order, fixed cost per line.
  task automatic load_expect(input bit mode, input int delay);
    automatic int n = sweep_set.size();
    sweep_set.sort();
    ack_delay = delay;
    foreach (sweep_set[i]) begin
      set_q.push_back(sweep_set[i]);
      if (!mode) exp_wb.push_back('{sweep_set[i], delay + 1});
      exp_clr.push_back(sweep_set[i]);
    end
    exp_done.push_back('{LINES + 1 + n * (mode ? 1 : delay + 2), n});
  endtask

  task automatic wait_idle();
    automatic int k = 0;
    while (flush_busy && k < BOUND) begin
      @(negedge globalclock);
      k++;
    end
    if (k >= BOUND) chk("idle_timeout", longint'(flush_busy), 0);
  endtask

  task automatic wait_done(input int lines);
    automatic int k = 0;
    while (flush_done !== 1'b1 && k < BOUND) begin
      @(negedge globalclock);
      flush_mode = 1'($urandom_range(0, 1));
      k++;
    end
    if (k >= BOUND) chk("done_timeout", longint'(flush_done), 1);
    repeat (3) @(negedge globalclock);
    chk("lines_hold", longint'(lines_cleared), lines);
    chk("vmem_clean", $countones(vmem), 0);
  endtask

  task automatic run_sweep(input bit mode, input int delay);
    automatic int n = sweep_set.size();
    wait_idle();
    load_expect(mode, delay);
    @(negedge globalclock);
    flush_mode = mode;
    flush_req  = 1'b1;
    @(negedge globalclock);
    flush_req  = 1'b0;
    wait_done(n);
  endtask

  task automatic random_set();
    automatic int n = $urandom_range(0, 5);
    sweep_set.delete();
    if ($urandom_range(0, 1) == 1) sweep_set.push_back(LINES - 1);
    if ($urandom_range(0, 1) == 1) sweep_set.push_back(0);
    for (int i = 0; i < n; i++) begin
      automatic int v = $urandom_range(0, LINES - 1);
      automatic bit dup = 1'b0;
      foreach (sweep_set[j]) if (sweep_set[j] == v) dup = 1'b1;
      if (!dup) sweep_set.push_back(v);
    end
  endtask

  initial begin
    automatic int k;
    reset      = 1'b1;
    flush_req  = 1'b0;
    flush_mode = 1'b0;
    repeat (3) @(negedge globalclock);
    chk("reset_outputs", longint'({flush_busy, flush_done, vm_wrEn, vm_inValidity, wb_req,
                                   vm_address, wb_index, lines_cleared}), 0);
    #2 reset = 1'b0;
    @(negedge globalclock);
    chk("post_reset_busy", longint'(flush_busy), 0);

    sweep_set.delete();
    run_sweep(1'b0, 0);

    sweep_set = '{0, 5, 1023};
    run_sweep(1'b0, 3);
    sweep_set = '{0, 5, 1023};
    run_sweep(1'b1, 0);

    stray_en = 1'b1;
    sweep_set = '{17, 400};
    run_sweep(1'b0, 10);
    for (int r = 0; r < 4; r++) begin
      random_set();
      run_sweep(1'($urandom_range(0, 1)), $urandom_range(0, 4));
    end
    stray_en = 1'b0;

    // Held request: mode changes mid-sweep must not leak in; next sweep follows one idle cycle.
    wait_idle();
    sweep_set = '{3, 700};
    load_expect(1'b1, 0);
    @(negedge globalclock);
    flush_mode = 1'b1;
    flush_req  = 1'b1;
    k = 0;
    while (!(flush_busy && vm_address >= 100) && k < BOUND) begin
      @(negedge globalclock);
      k++;
    end
    flush_mode = 1'b0;
    sweep_set = '{2, 4};
    load_expect(1'b0, 1);
    k = 0;
    while (flush_done !== 1'b1 && k < BOUND) begin
      @(negedge globalclock);
      k++;
    end
    k = 0;
    do begin
      @(negedge globalclock);
      k++;
    end while (!flush_busy && k < 10);
    #1;
    chk("held_gap", last_gap, 1);
    flush_req = 1'b0;
    wait_done(2);

    // Reset in the middle of the writeback for line 5.
    wait_idle();
    sweep_set = '{0, 5};
    load_expect(1'b0, 10);
    @(negedge globalclock);
    flush_mode = 1'b0;
    flush_req  = 1'b1;
    @(negedge globalclock);
    flush_req  = 1'b0;
    k = 0;
    while (!(wb_req && wb_index == 5) && k < BOUND) begin
      @(negedge globalclock);
      k++;
    end
    chk("reach_wb5", longint'(wb_index), 5);
    repeat (2) @(negedge globalclock);
    #2 reset = 1'b1;
    #1;
    chk("midwb_reset_outputs", longint'({flush_busy, flush_done, vm_wrEn, vm_inValidity, wb_req,
                                         vm_address, wb_index, lines_cleared}), 0);
    exp_wb.delete();
    exp_clr.delete();
    exp_done.delete();
    @(negedge globalclock);
    #2 reset = 1'b0;
    sweep_set = '{0, 9};
    run_sweep(1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/valid_sweep_ctrl.md
VALID_SWEEP_CTRL -- requirements
Module: valid_sweep_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 1024, number of cache lines swept.
REQ-002 SHALL have parameter INDEX_W, default 10, width of the line index; LINES = 2**INDEX_W.
REQ-003 SHALL have port globalclock, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port flush_req, input, 1, start request, level-sampled in IDLE.
REQ-006 SHALL have port flush_mode, input, 1, 0 = writeback+invalidate, 1 = invalidate-only, captured with flush_req.
REQ-007 SHALL have port flush_busy, output, 1, high in every state except IDLE.
REQ-008 SHALL have port flush_done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port vm_address, output, INDEX_W, line index to the VMemory address port.
REQ-010 SHALL have port vm_wrEn, output, 1, VMemory write enable.
REQ-011 SHALL have port vm_inValidity, output, 1, VMemory write data, constant 0.
REQ-012 SHALL have port vm_isValid, input, 1, combinational VMemory read of vm_address.
REQ-013 SHALL have port wb_req, output, 1, writeback request to the RAM interface.
REQ-014 SHALL have port wb_index, output, INDEX_W, index of the line to write back.
REQ-015 SHALL have port wb_ack, input, 1, writeback accepted and complete.
REQ-016 SHALL have port lines_cleared, output, INDEX_W+1, count of lines invalidated in the current or last sweep.

Function
REQ-017 SHALL implement the states IDLE, CHECK, WB, CLEAR and DONE.
REQ-018 IDLE: flush_req=1 at an edge SHALL set idx=0, capture flush_mode, zero lines_cleared, and go to CHECK.
REQ-019 CHECK: vm_isValid=0 SHALL advance; vm_isValid=1 with mode 0 SHALL go to WB; vm_isValid=1 with mode 1 SHALL go to CLEAR.
REQ-020 WB: wb_req=1 and wb_index=idx SHALL be held stable until wb_ack=1 is sampled, then the block SHALL go to CLEAR; ack in the first WB cycle is legal.
REQ-021 CLEAR: vm_wrEn=1 and vm_address=idx for exactly one cycle, lines_cleared+1, then advance.
REQ-022 Advance: idx==LINES-1 SHALL go to DONE, otherwise idx+1 and CHECK; idx SHALL never wrap to 0 within a sweep.
REQ-023 DONE: flush_done=1 for one cycle, then IDLE; a held flush_req SHALL start a new sweep only from IDLE, i.e. at least one IDLE cycle between sweeps.
REQ-024 vm_address SHALL equal idx in CHECK/WB/CLEAR/DONE and 0 in IDLE; vm_wrEn SHALL be 1 only in CLEAR.
REQ-025 flush_req and flush_mode SHALL be ignored outside IDLE; wb_ack SHALL be ignored outside WB.
REQ-026 All-invalid sweep latency: flush_done SHALL be high exactly LINES+1 cycles after the accepting edge.
REQ-027 Each valid line SHALL add 1 cycle (mode 1), or 2 cycles plus the ack wait (mode 0).
REQ-028 lines_cleared SHALL hold its value after DONE until the next sweep starts.

Reset
REQ-029 reset SHALL asynchronously force IDLE, idx=0, lines_cleared=0, and all outputs 0, including mid-sweep and mid-WB.
REQ-030 A pending writeback aborted by reset SHALL NOT be reissued; the RAM interface and VMemory are reset by the same reset.

Structure
REQ-031 A shared package valid_sweep_pkg SHALL hold the state enum type plus the LINES and INDEX_W defaults.
REQ-032 SHALL be a single module with no sub-module; it is instantiated beside VMemory at the cache top, and wb_* connect to the RAM interface.

Verification
REQ-033 All lines invalid, flush_req pulse, mode 0 -> no wb_req, no vm_wrEn, flush_done at cycle 1025, lines_cleared=0.
REQ-034 Lines 0, 5 and 1023 valid, mode 0, wb_ack 3 cycles after each wb_req -> wb_index 0, 5, 1023 in order, each line cleared once after its ack, lines_cleared=3.
REQ-035 Same valid set, mode 1 -> no wb_req, three vm_wrEn pulses, flush_done at cycle 1028.
REQ-036 Reset asserted while in WB for line 5 -> all outputs 0 immediately; a new sweep restarts from index 0.
REQ-037 flush_req held high continuously, flush_mode toggled mid-sweep -> mode unchanged during the sweep, one IDLE cycle after DONE, then a second sweep starts.
REQ-038 wb_ack pulsed in IDLE and CHECK -> no effect; wb_req held stable for 10 cycles until ack.
